// File: rtl/pc_fetch_unit.sv
// Fetch front end: holds the architectural PC, fetches over a valid/ready IM port and hands words to decode.
// Optional FETCH_ALIGN_CHK_EN: misaligned next-PC traps into a sticky fault state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        npc_load,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] fetch_cnt,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC
`ifdef FETCH_ALIGN_CHK_EN
        , S_FAULT
`endif
    } state_t;

    state_t state;
    logic   load_now;

    // npc is only taken when the held instruction has retired (hand-off done or in execute)
    assign load_now  = npc_load && ((state == S_HOLD && inst_ready) || state == S_EXEC);
    assign imem_addr = {pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            inst           <= 32'h0;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            fetch_cnt      <= 32'h0;
            fetch_fault    <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst       <= imem_rsp_data;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt  <= fetch_cnt + 32'd1;
                        inst_valid <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                default: ;
            endcase

            // Overrides the S_HOLD -> S_EXEC step when retire coincides with the hand-off
            if (load_now) begin
                pc <= npc;
`ifdef FETCH_ALIGN_CHK_EN
                if (npc[1:0] != 2'b00) begin
                    state       <= S_FAULT;
                    fetch_fault <= 1'b1;
                end else
`endif
                begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
            end
        end
    end

endmodule
